// File: rtl/sync_vg_prog.sv
// sync_vg_prog: runtime-programmable video timing generator.
// Produces registered HS/VS/DE, active-pixel coordinates and frame/line strobes.
// A new timing set is offered over a valid/ready handshake. It is checked for
// legality, held in a pending register, and swapped in only at the last pixel
// of a frame, so the active timing never changes mid-frame.
// Ports:
//   i_clk, i_rst                  pixel clock, synchronous active-high reset
//   i_cfg_valid / o_cfg_ready     config handshake (ready = nothing pending)
//   i_cfg_h_* / i_cfg_v_*         offered horizontal / vertical timing fields
//   i_cfg_hs_pol / i_cfg_vs_pol   offered sync polarity (1 = active-high)
//   o_cfg_applied                 pulse on the first output cycle of a new timing
//   o_cfg_err                     pulse the cycle after an illegal offer
//   o_hs_out, o_vs_out, o_de_out  timing outputs
//   o_x_act, o_y_act              active-pixel column / row (0 outside active)
//   o_frame_start, o_line_start   strobes for h_cnt==0 (and v_cnt==0)
module sync_vg_prog #(
  parameter int unsigned X_BITS  = 12,
  parameter int unsigned Y_BITS  = 12,
  parameter int unsigned H_TOTAL = 1650,
  parameter int unsigned H_SYNC  = 40,
  parameter int unsigned H_BP    = 220,
  parameter int unsigned H_ACT   = 1280,
  parameter int unsigned V_TOTAL = 750,
  parameter int unsigned V_SYNC  = 5,
  parameter int unsigned V_BP    = 20,
  parameter int unsigned V_ACT   = 720,
  parameter int unsigned HS_POL  = 1,
  parameter int unsigned VS_POL  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [X_BITS-1:0] i_cfg_h_total,
  input  logic [X_BITS-1:0] i_cfg_h_sync,
  input  logic [X_BITS-1:0] i_cfg_h_bp,
  input  logic [X_BITS-1:0] i_cfg_h_act,
  input  logic [Y_BITS-1:0] i_cfg_v_total,
  input  logic [Y_BITS-1:0] i_cfg_v_sync,
  input  logic [Y_BITS-1:0] i_cfg_v_bp,
  input  logic [Y_BITS-1:0] i_cfg_v_act,
  input  logic              i_cfg_hs_pol,
  input  logic              i_cfg_vs_pol,
  output logic              o_cfg_applied,
  output logic              o_cfg_err,
  output logic              o_hs_out,
  output logic              o_vs_out,
  output logic              o_de_out,
  output logic [X_BITS-1:0] o_x_act,
  output logic [Y_BITS-1:0] o_y_act,
  output logic              o_frame_start,
  output logic              o_line_start
);

  typedef struct packed {
    logic [X_BITS-1:0] h_total;
    logic [X_BITS-1:0] h_sync;
    logic [X_BITS-1:0] h_bp;
    logic [X_BITS-1:0] h_act;
    logic [Y_BITS-1:0] v_total;
    logic [Y_BITS-1:0] v_sync;
    logic [Y_BITS-1:0] v_bp;
    logic [Y_BITS-1:0] v_act;
    logic              hs_pol;
    logic              vs_pol;
  } cfg_t;

  cfg_t              w_cfg_dflt;
  cfg_t              w_cfg_in;
  cfg_t              r_act;
  cfg_t              r_pend;
  logic              r_pending;
  logic              r_apply_q;
  logic [X_BITS-1:0] r_h_cnt;
  logic [Y_BITS-1:0] r_v_cnt;

  assign w_cfg_dflt = '{
    h_total: X_BITS'(H_TOTAL), h_sync: X_BITS'(H_SYNC),
    h_bp:    X_BITS'(H_BP),    h_act:  X_BITS'(H_ACT),
    v_total: Y_BITS'(V_TOTAL), v_sync: Y_BITS'(V_SYNC),
    v_bp:    Y_BITS'(V_BP),    v_act:  Y_BITS'(V_ACT),
    hs_pol:  (HS_POL != 0),    vs_pol: (VS_POL != 0)
  };

  assign w_cfg_in = '{
    h_total: i_cfg_h_total, h_sync: i_cfg_h_sync, h_bp: i_cfg_h_bp, h_act: i_cfg_h_act,
    v_total: i_cfg_v_total, v_sync: i_cfg_v_sync, v_bp: i_cfg_v_bp, v_act: i_cfg_v_act,
    hs_pol:  i_cfg_hs_pol,  vs_pol: i_cfg_vs_pol
  };

  // Legality of the offered config; three-term sums get two spare bits.
  logic [X_BITS+1:0] w_h_need;
  logic [Y_BITS+1:0] w_v_need;
  logic              w_legal;
  logic              w_xfer;

  assign w_h_need = {2'b00, i_cfg_h_sync} + {2'b00, i_cfg_h_bp} + {2'b00, i_cfg_h_act};
  assign w_v_need = {2'b00, i_cfg_v_sync} + {2'b00, i_cfg_v_bp} + {2'b00, i_cfg_v_act};
  assign w_legal  = (w_h_need <= {2'b00, i_cfg_h_total}) &&
                    (w_v_need <= {2'b00, i_cfg_v_total}) &&
                    (i_cfg_h_sync != '0) && (i_cfg_h_act != '0) &&
                    (i_cfg_v_sync != '0) && (i_cfg_v_act != '0) &&
                    (i_cfg_h_total >= X_BITS'(4)) && (i_cfg_v_total >= Y_BITS'(2));
  // Handshake and apply are mutually exclusive: one needs pending clear, the other set.
  assign w_xfer      = i_cfg_valid && !r_pending;
  assign o_cfg_ready = !r_pending;

  // Decode of the current counter state against the active timing.
  logic [X_BITS:0]   w_h_start;
  logic [X_BITS+1:0] w_h_end;
  logic [Y_BITS:0]   w_v_start;
  logic [Y_BITS+1:0] w_v_end;
  logic              w_h_in;
  logic              w_v_in;
  logic [X_BITS-1:0] w_x;
  logic [Y_BITS-1:0] w_y;
  logic              w_h_last;
  logic              w_v_last;
  logic              w_apply;

  assign w_h_start = {1'b0, r_act.h_sync} + {1'b0, r_act.h_bp};
  assign w_h_end   = {1'b0, w_h_start} + {2'b00, r_act.h_act};
  assign w_v_start = {1'b0, r_act.v_sync} + {1'b0, r_act.v_bp};
  assign w_v_end   = {1'b0, w_v_start} + {2'b00, r_act.v_act};
  assign w_h_in    = ({1'b0, r_h_cnt} >= w_h_start) && ({2'b00, r_h_cnt} < w_h_end);
  assign w_v_in    = ({1'b0, r_v_cnt} >= w_v_start) && ({2'b00, r_v_cnt} < w_v_end);
  // Only used while inside the span, where the difference cannot go negative.
  assign w_x       = r_h_cnt - w_h_start[X_BITS-1:0];
  assign w_y       = r_v_cnt - w_v_start[Y_BITS-1:0];
  assign w_h_last  = ({1'b0, r_h_cnt} + (X_BITS+1)'(1)) == {1'b0, r_act.h_total};
  assign w_v_last  = ({1'b0, r_v_cnt} + (Y_BITS+1)'(1)) == {1'b0, r_act.v_total};
  assign w_apply   = w_h_last && w_v_last && r_pending;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_act         <= w_cfg_dflt;
      r_pend        <= w_cfg_dflt;
      r_pending     <= 1'b0;
      r_apply_q     <= 1'b0;
      o_cfg_applied <= 1'b0;
      o_cfg_err     <= 1'b0;
      o_hs_out      <= (HS_POL == 0);
      o_vs_out      <= (VS_POL == 0);
      o_de_out      <= 1'b0;
      o_x_act       <= '0;
      o_y_act       <= '0;
      o_frame_start <= 1'b0;
      o_line_start  <= 1'b0;
    end else begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + Y_BITS'(1);
      end else begin
        r_h_cnt <= r_h_cnt + X_BITS'(1);
      end

      if (w_apply) begin
        r_act     <= r_pend;
        r_pending <= 1'b0;
      end else if (w_xfer && w_legal) begin
        r_pend    <= w_cfg_in;
        r_pending <= 1'b1;
      end

      // Two stages so the pulse lines up with the decode of the new frame's first pixel.
      r_apply_q     <= w_apply;
      o_cfg_applied <= r_apply_q;
      o_cfg_err     <= w_xfer && !w_legal;

      o_hs_out      <= (r_h_cnt < r_act.h_sync) ^ !r_act.hs_pol;
      o_vs_out      <= (r_v_cnt < r_act.v_sync) ^ !r_act.vs_pol;
      o_de_out      <= w_h_in && w_v_in;
      o_x_act       <= w_h_in ? w_x : '0;
      o_y_act       <= w_v_in ? w_y : '0;
      o_line_start  <= (r_h_cnt == '0);
      o_frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_sync_vg_prog.sv
// Bench for sync_vg_prog. Uses a reduced default timing (50x24) so that whole
// frames fit the cycle budget; the tiny mode is 16x10.
module tb_sync_vg_prog;

  localparam int DHT = 50, DHS = 4, DHB = 6, DHA = 32;
  localparam int DVT = 24, DVS = 2, DVB = 3, DVA = 16;

  typedef struct {
    int ht; int hs; int hb; int ha;
    int vt; int vs; int vb; int va;
    bit hp; bit vp;
  } tcfg_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [11:0] cfg_h_total, cfg_h_sync, cfg_h_bp, cfg_h_act;
  logic [11:0] cfg_v_total, cfg_v_sync, cfg_v_bp, cfg_v_act;
  logic        cfg_hs_pol, cfg_vs_pol;
  logic        cfg_applied, cfg_err, hs_out, vs_out, de_out, frame_start, line_start;
  logic [11:0] x_act, y_act;

  always #5 clk = ~clk;

  sync_vg_prog #(
    .X_BITS(12), .Y_BITS(12),
    .H_TOTAL(DHT), .H_SYNC(DHS), .H_BP(DHB), .H_ACT(DHA),
    .V_TOTAL(DVT), .V_SYNC(DVS), .V_BP(DVB), .V_ACT(DVA),
    .HS_POL(1), .VS_POL(1)
  ) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_h_total(cfg_h_total), .i_cfg_h_sync(cfg_h_sync),
    .i_cfg_h_bp(cfg_h_bp), .i_cfg_h_act(cfg_h_act),
    .i_cfg_v_total(cfg_v_total), .i_cfg_v_sync(cfg_v_sync),
    .i_cfg_v_bp(cfg_v_bp), .i_cfg_v_act(cfg_v_act),
    .i_cfg_hs_pol(cfg_hs_pol), .i_cfg_vs_pol(cfg_vs_pol),
    .o_cfg_applied(cfg_applied), .o_cfg_err(cfg_err),
    .o_hs_out(hs_out), .o_vs_out(vs_out), .o_de_out(de_out),
    .o_x_act(x_act), .o_y_act(y_act),
    .o_frame_start(frame_start), .o_line_start(line_start)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic tcfg_t mk(int ht, int hs, int hb, int ha, int vt, int vs, int vb, int va,
                               bit hp, bit vp);
    tcfg_t c;
    c.ht = ht; c.hs = hs; c.hb = hb; c.ha = ha;
    c.vt = vt; c.vs = vs; c.vb = vb; c.va = va;
    c.hp = hp; c.vp = vp;
    return c;
  endfunction

  function automatic bit legal(tcfg_t c);
    return (c.hs + c.hb + c.ha <= c.ht) && (c.vs + c.vb + c.va <= c.vt) &&
           (c.hs >= 1) && (c.ha >= 1) && (c.vs >= 1) && (c.va >= 1) &&
           (c.ht >= 4) && (c.vt >= 2);
  endfunction

  function automatic tcfg_t offered();
    return mk(int'(cfg_h_total), int'(cfg_h_sync), int'(cfg_h_bp), int'(cfg_h_act),
              int'(cfg_v_total), int'(cfg_v_sync), int'(cfg_v_bp), int'(cfg_v_act),
              cfg_hs_pol, cfg_vs_pol);
  endfunction

  task automatic set_cfg(input tcfg_t c);
    cfg_h_total = 12'(c.ht); cfg_h_sync = 12'(c.hs); cfg_h_bp = 12'(c.hb); cfg_h_act = 12'(c.ha);
    cfg_v_total = 12'(c.vt); cfg_v_sync = 12'(c.vs); cfg_v_bp = 12'(c.vb); cfg_v_act = 12'(c.va);
    cfg_hs_pol  = c.hp;      cfg_vs_pol = c.vp;
  endtask

  // Reference model: frame position as one linear pixel index, outputs from plain arithmetic.
  tcfg_t dflt, m_act, m_pend;
  bit    m_live = 0, m_pending, m_apply_pipe;
  int    m_pos;
  bit    e_hs, e_vs, e_de, e_ready, e_app, e_err, e_fs, e_ls;
  int    e_x, e_y;

  initial dflt = mk(DHT, DHS, DHB, DHA, DVT, DVS, DVB, DVA, 1'b1, 1'b1);

  always @(posedge clk) begin : p_model
    int h, v, hx, vy;
    bit acc, hin, vin;
    tcfg_t c;
    if (rst) begin
      m_live = 1; m_pos = 0; m_act = dflt; m_pending = 0; m_apply_pipe = 0;
      e_hs = 1'b0; e_vs = 1'b0; e_de = 0; e_x = 0; e_y = 0;
      e_ready = 1; e_app = 0; e_err = 0; e_fs = 0; e_ls = 0;
    end else if (m_live) begin
      h  = m_pos % m_act.ht;
      v  = m_pos / m_act.ht;
      hx = h - (m_act.hs + m_act.hb);
      vy = v - (m_act.vs + m_act.vb);
      hin = (hx >= 0) && (hx < m_act.ha);
      vin = (vy >= 0) && (vy < m_act.va);
      e_hs = (h < m_act.hs) ^ !m_act.hp;
      e_vs = (v < m_act.vs) ^ !m_act.vp;
      e_de = hin && vin;
      e_x  = hin ? hx : 0;
      e_y  = vin ? vy : 0;
      e_ls = (h == 0);
      e_fs = (m_pos == 0);
      e_app = m_apply_pipe;
      m_apply_pipe = 0;
      c   = offered();
      acc = cfg_valid && !m_pending;
      e_err = acc && !legal(c);
      if (m_pos == m_act.ht * m_act.vt - 1) begin
        m_pos = 0;
        if (m_pending) begin
          m_act = m_pend; m_pending = 0; m_apply_pipe = 1;
        end
      end else begin
        m_pos++;
      end
      if (acc && legal(c)) begin
        m_pend = c; m_pending = 1;
      end
      e_ready = !m_pending;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("hs_out", 32'(hs_out), 32'(e_hs));
      check("vs_out", 32'(vs_out), 32'(e_vs));
      check("de_out", 32'(de_out), 32'(e_de));
      check("x_act", 32'(x_act), 32'(e_x));
      check("y_act", 32'(y_act), 32'(e_y));
      check("line_start", 32'(line_start), 32'(e_ls));
      check("frame_start", 32'(frame_start), 32'(e_fs));
      check("cfg_ready", 32'(cfg_ready), 32'(e_ready));
      check("cfg_applied", 32'(cfg_applied), 32'(e_app));
      check("cfg_err", 32'(cfg_err), 32'(e_err));
    end
  end

  // Counts negedges until frame_start is seen.
  task automatic wait_fs(input int budget, output int per);
    per = 0;
    do begin
      @(negedge clk);
      per++;
    end while (!frame_start && per < budget);
    if (!frame_start) check("frame_start_timeout", 32'(0), 32'(1));
  endtask

  // Starting on a frame_start cycle, gathers statistics up to the next frame_start.
  task automatic measure_frame(input int budget, output int per, output int des, output int mx,
                               output int my, output int hs1);
    per = 0; des = 0; mx = 0; my = 0; hs1 = 0;
    do begin
      if (de_out) begin
        des++;
        if (int'(x_act) > mx) mx = int'(x_act);
        if (int'(y_act) > my) my = int'(y_act);
      end
      if (hs_out) hs1++;
      @(negedge clk);
      per++;
    end while (!frame_start && per < budget);
    if (!frame_start) check("frame_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    tcfg_t tiny, tiny_n, bad;
    int per, des, mx, my, hs1, hs_ones, hs_fall, first_de, fx, fy, lx, ly, last_de, aft_de, aft_x;
    tiny   = mk(16, 2, 3, 8, 10, 1, 2, 5, 1'b1, 1'b1);
    tiny_n = mk(16, 2, 3, 8, 10, 1, 2, 5, 1'b0, 1'b1);
    bad    = mk(10, 4, 4, 4, 10, 1, 2, 5, 1'b1, 1'b1);

    cfg_valid = 0;
    set_cfg(tiny);
    rst = 1;
    repeat (3) @(negedge clk);
    check("rst_hs", 32'(hs_out), 32'(0));
    check("rst_vs", 32'(vs_out), 32'(0));
    check("rst_de", 32'(de_out), 32'(0));
    check("rst_ready", 32'(cfg_ready), 32'(1));
    rst = 0;

    // First default frame.
    hs_ones = 0; hs_fall = -1; first_de = -1; fx = -1; fy = -1; lx = -1; ly = -1;
    last_de = -1; des = 0; aft_de = -1; aft_x = -1;
    for (int i = 0; i < DHT * DVT; i++) begin
      @(negedge clk);
      if (i == 0) check("first_frame_start", 32'(frame_start), 32'(1));
      if (i < DHT) begin
        hs_ones += int'(hs_out);
        if (!hs_out && hs_fall < 0) hs_fall = i;
      end
      if (last_de >= 0 && i == last_de + 1) begin
        aft_de = int'(de_out); aft_x = int'(x_act);
      end
      if (de_out) begin
        des++;
        if (first_de < 0) begin
          first_de = i; fx = int'(x_act); fy = int'(y_act);
        end
        lx = int'(x_act); ly = int'(y_act); last_de = i;
      end
    end
    check("hs_high_line0", 32'(hs_ones), 32'(4));
    check("hs_fall_index", 32'(hs_fall), 32'(4));
    check("first_de_index", 32'(first_de), 32'(260));
    check("first_de_x", 32'(fx), 32'(0));
    check("first_de_y", 32'(fy), 32'(0));
    check("de_per_frame", 32'(des), 32'(512));
    check("last_de_x", 32'(lx), 32'(31));
    check("last_de_y", 32'(ly), 32'(15));
    check("after_last_de", 32'(aft_de), 32'(0));
    check("after_last_x", 32'(aft_x), 32'(0));
    @(negedge clk);
    check("dflt_frame_len", 32'(frame_start), 32'(1));

    // Mid-frame reconfig at v_cnt around 10.
    repeat (499) @(negedge clk);
    set_cfg(tiny);
    cfg_valid = 1;
    @(negedge clk);
    cfg_valid = 0;
    check("reconf_ready_low", 32'(cfg_ready), 32'(0));
    wait_fs(3000, per);
    check("old_frame_len", 32'(500 + per), 32'(1200));
    check("applied_with_fs", 32'(cfg_applied), 32'(1));
    measure_frame(3000, per, des, mx, my, hs1);
    check("tiny_len", 32'(per), 32'(160));
    check("tiny_de", 32'(des), 32'(40));
    check("tiny_max_x", 32'(mx), 32'(7));
    check("tiny_max_y", 32'(my), 32'(4));
    check("tiny_hs_high", 32'(hs1), 32'(20));

    // Illegal offer.
    set_cfg(bad);
    cfg_valid = 1;
    @(negedge clk);
    cfg_valid = 0;
    check("illegal_err", 32'(cfg_err), 32'(1));
    check("illegal_ready", 32'(cfg_ready), 32'(1));
    @(negedge clk);
    check("illegal_err_once", 32'(cfg_err), 32'(0));
    wait_fs(3000, per);
    for (int f = 0; f < 2; f++) begin
      measure_frame(3000, per, des, mx, my, hs1);
      check("illegal_frame_len", 32'(per), 32'(160));
      check("illegal_frame_de", 32'(des), 32'(40));
    end

    // Polarity change offered exactly on the last-pixel cycle.
    repeat (158) @(negedge clk);
    set_cfg(tiny_n);
    cfg_valid = 1;
    @(negedge clk);
    cfg_valid = 0;
    check("boundary_accept", 32'(cfg_ready), 32'(0));
    wait_fs(3000, per);
    check("boundary_fs_next", 32'(per), 32'(1));
    check("boundary_not_applied", 32'(cfg_applied), 32'(0));
    measure_frame(3000, per, des, mx, my, hs1);
    check("old_pol_hs_high", 32'(hs1), 32'(20));
    check("pol_applied", 32'(cfg_applied), 32'(1));
    measure_frame(3000, per, des, mx, my, hs1);
    check("new_pol_hs_high", 32'(hs1), 32'(140));
    check("new_pol_len", 32'(per), 32'(160));

    // Randomized offers, with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      set_cfg(mk($urandom_range(3, 20), $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 10), $urandom_range(1, 8), $urandom_range(0, 3),
                 $urandom_range(0, 2), $urandom_range(0, 5),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))));
      @(negedge clk);
    end
    rst = 0;
    cfg_valid = 0;

    // Reset while a config is pending.
    per = 0;
    while (!cfg_ready && per < 3000) begin
      @(negedge clk);
      per++;
    end
    check("ready_before_rst", 32'(cfg_ready), 32'(1));
    set_cfg(tiny);
    cfg_valid = 1;
    @(negedge clk);
    cfg_valid = 0;
    check("pending_before_rst", 32'(cfg_ready), 32'(0));
    rst = 1;
    repeat (2) @(negedge clk);
    check("rst_drops_pending", 32'(cfg_ready), 32'(1));
    rst = 0;
    @(negedge clk);
    check("post_rst_fs", 32'(frame_start), 32'(1));
    measure_frame(3000, per, des, mx, my, hs1);
    check("post_rst_len", 32'(per), 32'(1200));
    check("post_rst_de", 32'(des), 32'(512));
    check("post_rst_max_x", 32'(mx), 32'(31));
    check("post_rst_max_y", 32'(my), 32'(15));
    check("post_rst_hs_high", 32'(hs1), 32'(96));
    check("post_rst_no_apply", 32'(cfg_applied), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
